// File: rtl/moonpatrol_input_pkg.sv
// Shared definitions for the Moon Patrol input conditioning block.
// Holds the joystick word bit indices and the coin pulser state type.
package moonpatrol_input_pkg;

    // Joystick word bit map (same for both players)
    localparam int unsigned JOY_R      = 0;
    localparam int unsigned JOY_L      = 1;
    localparam int unsigned JOY_D      = 2;
    localparam int unsigned JOY_U      = 3;
    localparam int unsigned JOY_FIRE   = 4;
    localparam int unsigned JOY_JUMP   = 5;
    localparam int unsigned JOY_START1 = 6;
    localparam int unsigned JOY_START2 = 7;
    localparam int unsigned JOY_COIN   = 8;
    localparam int unsigned JOY_PAUSE  = 9;

    localparam int unsigned JOY_W = 16;
    localparam int unsigned DIM_W = 32;

    typedef enum logic [1:0] {
        COIN_IDLE    = 2'd0,
        COIN_ACTIVE  = 2'd1,
        COIN_HOLDOFF = 2'd2,
        COIN_WAITREL = 2'd3
    } coin_state_t;

endpackage

// File: rtl/coin_pulser.sv
// Coin pulse shaper: a rising edge on coin_in yields a fixed-length high
// pulse followed by a fixed low gap; the input must then be released before
// another pulse can start. Edges seen while busy are dropped, not queued.
// Ports:
//   clk_sys  - system clock
//   reset    - synchronous, active-high reset
//   coin_in  - raw coin button
//   coin_out - shaped coin pulse (registered)
module coin_pulser
    import moonpatrol_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE = 4_000_000,
    parameter int unsigned COIN_GAP   = 3_000_000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic coin_in,
    output logic coin_out
);

    localparam int unsigned PULSE_W = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
    localparam int unsigned GAP_W   = (COIN_GAP > 1)   ? $clog2(COIN_GAP)   : 1;
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(COIN_PULSE - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(COIN_GAP - 1);

    coin_state_t        state;
    logic [PULSE_W-1:0] pulse_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               coin_prev;
    logic               coin_rise;

    assign coin_rise = coin_in & ~coin_prev;

    // Previous sample resets high so a button held through reset is not an edge
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= COIN_IDLE;
            pulse_cnt <= '0;
            gap_cnt   <= '0;
            coin_prev <= 1'b1;
            coin_out  <= 1'b0;
        end else begin
            coin_prev <= coin_in;
            case (state)
                COIN_IDLE: begin
                    if (coin_rise) begin
                        state     <= COIN_ACTIVE;
                        pulse_cnt <= '0;
                        coin_out  <= 1'b1;
                    end
                end
                COIN_ACTIVE: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state    <= COIN_HOLDOFF;
                        gap_cnt  <= '0;
                        coin_out <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt + PULSE_W'(1);
                    end
                end
                COIN_HOLDOFF: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= coin_in ? COIN_WAITREL : COIN_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                COIN_WAITREL: begin
                    if (!coin_in) begin
                        state <= COIN_IDLE;
                    end
                end
                default: begin
                    state    <= COIN_IDLE;
                    coin_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/moonpatrol_input_cond.sv
// Input conditioning for the Moon Patrol core: merges both joystick words,
// shapes each player's coin into a long pulse, and produces a pause request
// plus a screen-dim flag after a long user pause.
// Ports:
//   clk_sys      - system clock
//   reset        - synchronous, active-high reset
//   joy_0, joy_1 - player joystick words (R,L,D,U,fire,jump,start1,start2,coin,pause)
//   osd_status   - OSD open
//   osd_pause_en - pause while OSD open
//   hs_access    - hiscore engine halt request
//   joy1_out     - {coin1,start1,jump,fire,U,D,L,R}
//   joy2_out     - {coin2,start2,jump,fire,U,D,L,R}
//   pause        - core halt request
//   dim_video    - halve video intensity
module moonpatrol_input_cond
    import moonpatrol_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE  = 4_000_000,
    parameter int unsigned COIN_GAP    = 3_000_000,
    parameter int unsigned DIM_TIMEOUT = 300_000_000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [JOY_W-1:0]  joy_0,
    input  logic [JOY_W-1:0]  joy_1,
    input  logic              osd_status,
    input  logic              osd_pause_en,
    input  logic              hs_access,
    output logic [7:0]        joy1_out,
    output logic [7:0]        joy2_out,
    output logic              pause,
    output logic              dim_video
);

    localparam logic [DIM_W-1:0] DIM_LIMIT = DIM_W'(DIM_TIMEOUT);

    logic [JOY_W-1:0] joy_c;
    logic [6:0]       p1_q;
    logic [6:0]       p2_q;
    logic             coin1;
    logic             coin2;
    logic             pause_prev;
    logic             pause_toggle;
    logic             pause_toggle_nxt;
    logic [DIM_W-1:0] dim_cnt;
    logic [DIM_W-1:0] dim_cnt_nxt;
    logic             unused_bits;

    assign joy_c       = joy_0 | joy_1;
    assign unused_bits = ^{joy_c[JOY_W-1:JOY_PAUSE+1], joy_c[JOY_COIN]};

    // Coins stay per-player so two simultaneous coins give two credits
    coin_pulser #(.COIN_PULSE(COIN_PULSE), .COIN_GAP(COIN_GAP)) u_coin1 (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .coin_in  (joy_0[JOY_COIN]),
        .coin_out (coin1)
    );

    coin_pulser #(.COIN_PULSE(COIN_PULSE), .COIN_GAP(COIN_GAP)) u_coin2 (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .coin_in  (joy_1[JOY_COIN]),
        .coin_out (coin2)
    );

    // Next toggle feeds pause directly so a button press shows after one cycle
    always_comb begin
        pause_toggle_nxt = pause_toggle ^ (joy_c[JOY_PAUSE] & ~pause_prev);
        dim_cnt_nxt      = dim_cnt;
        if (!pause_toggle) begin
            dim_cnt_nxt = '0;
        end else if (dim_cnt < DIM_LIMIT) begin
            dim_cnt_nxt = dim_cnt + DIM_W'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            p1_q         <= '0;
            p2_q         <= '0;
            pause_prev   <= 1'b1;
            pause_toggle <= 1'b0;
            dim_cnt      <= '0;
            pause        <= 1'b0;
            dim_video    <= 1'b0;
        end else begin
            p1_q <= {joy_c[JOY_START1], joy_c[JOY_JUMP], joy_c[JOY_FIRE],
                     joy_c[JOY_U], joy_c[JOY_D], joy_c[JOY_L], joy_c[JOY_R]};
            p2_q <= {joy_c[JOY_START2], joy_c[JOY_JUMP], joy_c[JOY_FIRE],
                     joy_c[JOY_U], joy_c[JOY_D], joy_c[JOY_L], joy_c[JOY_R]};
            pause_prev   <= joy_c[JOY_PAUSE];
            pause_toggle <= pause_toggle_nxt;
            dim_cnt      <= dim_cnt_nxt;
            pause        <= pause_toggle_nxt | hs_access | (osd_status & osd_pause_en);
            dim_video    <= (dim_cnt_nxt >= DIM_LIMIT);
        end
    end

    assign joy1_out = {coin1, p1_q};
    assign joy2_out = {coin2, p2_q};

endmodule

// File: tb/tb_moonpatrol_input_cond.sv
// Scoreboard bench for moonpatrol_input_cond: the driver computes expected
// outputs from an event-level reference model and queues them; a monitor
// compares them against the DUT on the falling edge.
module tb_moonpatrol_input_cond;

    localparam int P = 4;
    localparam int G = 3;
    localparam int D = 10;

    logic        clk_sys      = 1'b0;
    logic        reset        = 1'b1;
    logic [15:0] joy_0        = '0;
    logic [15:0] joy_1        = '0;
    logic        osd_status   = 1'b0;
    logic        osd_pause_en = 1'b0;
    logic        hs_access    = 1'b0;
    logic [7:0]  joy1_out;
    logic [7:0]  joy2_out;
    logic        pause;
    logic        dim_video;

    moonpatrol_input_cond #(
        .COIN_PULSE(P), .COIN_GAP(G), .DIM_TIMEOUT(D)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .joy_0        (joy_0),
        .joy_1        (joy_1),
        .osd_status   (osd_status),
        .osd_pause_en (osd_pause_en),
        .hs_access    (hs_access),
        .joy1_out     (joy1_out),
        .joy2_out     (joy2_out),
        .pause        (pause),
        .dim_video    (dim_video)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         cyc;
        logic [7:0] j1;
        logic [7:0] j2;
        logic       p;
        logic       d;
    } exp_t;

    exp_t sb[$];

    // Reference model: a coin fires on a rising edge no earlier than
    // P+G+1 cycles after the previous accepted one, and is high P cycles.
    int last1 = -1000;
    int last2 = -1000;
    bit prev1 = 1'b1;
    bit prev2 = 1'b1;
    bit prevp = 1'b1;
    bit tog   = 1'b0;
    int dimc  = 0;

    task automatic drive(input logic [15:0] j0, input logic [15:0] j1,
                         input logic osd, input logic en, input logic hs,
                         input logic rst);
        exp_t        e;
        logic [15:0] jc;
        logic        c1;
        logic        c2;
        @(posedge clk_sys);
        #1;
        joy_0        = j0;
        joy_1        = j1;
        osd_status   = osd;
        osd_pause_en = en;
        hs_access    = hs;
        reset        = rst;
        e.cyc = cyc + 1;
        jc    = j0 | j1;
        if (rst) begin
            prev1 = 1'b1; prev2 = 1'b1; prevp = 1'b1;
            tog = 1'b0; dimc = 0; last1 = -1000; last2 = -1000;
            e.j1 = '0; e.j2 = '0; e.p = 1'b0; e.d = 1'b0;
        end else begin
            if (j0[8] && !prev1 && e.cyc >= last1 + P + G + 1) last1 = e.cyc;
            if (j1[8] && !prev2 && e.cyc >= last2 + P + G + 1) last2 = e.cyc;
            prev1 = j0[8];
            prev2 = j1[8];
            if (!tog) dimc = 0;
            else if (dimc < D) dimc = dimc + 1;
            if (jc[9] && !prevp) tog = !tog;
            prevp = jc[9];
            c1 = (e.cyc >= last1) && (e.cyc < last1 + P);
            c2 = (e.cyc >= last2) && (e.cyc < last2 + P);
            e.j1 = {c1, jc[6:0]};
            e.j2 = {c2, jc[7], jc[5:0]};
            e.p  = tog | hs | (osd & en);
            e.d  = (dimc >= D);
        end
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int at, input logic [7:0] act,
                       input logic [7:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            errors = errors + 1;
            $display("FAIL %s cycle %0d: got %h expected %h", name, at, act, expv);
        end
    endtask

    // Monitor: compare every queued expectation on the cycle it belongs to
    always @(negedge clk_sys) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL stale_entry cycle %0d: got no sample expected one at %0d", cyc, e.cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("joy1_out",  cyc, joy1_out,      e.j1);
            chk("joy2_out",  cyc, joy2_out,      e.j2);
            chk("pause",     cyc, 8'(pause),     8'(e.p));
            chk("dim_video", cyc, 8'(dim_video), 8'(e.d));
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset with player-1 coin held across release: no pulse allowed
        for (int i = 0; i < 3; i++) drive(16'h0100, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) drive(16'h0100, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Merged direction/button bits
        drive(16'h0001, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(16'h0080, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(16'hFC5A, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Single-cycle coin on player 1
        drive(16'h0100, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(10);

        // Player-2 coin held 20 cycles, then quick re-presses
        for (int i = 0; i < 20; i++) drive(16'h0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        drive(16'h0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(10);
        drive(16'h0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);
        drive(16'h0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(10);

        // Simultaneous coins
        drive(16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(10);

        // Pause toggle, dim after timeout, second press clears
        drive(16'h0200, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(14);
        drive(16'h0200, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        // Held pause toggles once
        for (int i = 0; i < 12; i++) drive(16'h0, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(16'h0200, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Hiscore and OSD halt requests never dim
        for (int i = 0; i < 50; i++) drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) drive(16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)  drive(16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Reset on the second cycle of a pulse, then a fresh coin
        drive(16'h0100, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        drive(16'h0100, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(8);

        // Randomized traffic
        for (int n = 0; n < 350; n++) begin
            logic [15:0] a;
            logic [15:0] b;
            logic        o;
            logic        oe;
            logic        h;
            logic        r;
            int          hold;
            a     = 16'($urandom);
            b     = 16'($urandom);
            a[8]  = ($urandom_range(0, 2) == 0);
            b[8]  = ($urandom_range(0, 2) == 0);
            a[9]  = ($urandom_range(0, 11) == 0);
            b[9]  = ($urandom_range(0, 15) == 0);
            o     = ($urandom_range(0, 5) == 0);
            oe    = 1'($urandom_range(0, 1));
            h     = ($urandom_range(0, 9) == 0);
            r     = ($urandom_range(0, 99) == 0);
            hold  = int'($urandom_range(1, 6));
            for (int k = 0; k < hold; k++) drive(a, b, o, oe, h, r);
        end
        idle(3);

        repeat (2) @(negedge clk_sys);
        #1;
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
